// File: rtl/operand_sequencer_pkg.sv
// Shared definitions for the operand sequencer front end: op codes, step
// state codes and default button timing.
package operand_sequencer_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEFAULT_SYNC_STAGES     = 2;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOT = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    SEL_OP = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    RUN    = 3'd3,
    SHOW   = 3'd4
  } step_t;

  function automatic logic is_unary(input op_t op);
    return op == OP_NOT;
  endfunction

endpackage

// File: rtl/operand_sequencer_key_debounce.sv
// Pushbutton conditioner: synchronizer, stable-level debounce counter and a
// one-cycle strobe on each accepted press (falling edge of the accepted level).
module key_debounce
  import operand_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic pressPulse,
  output logic level
);

  localparam int unsigned    CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   r_pulse;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // The counter only runs while the synchronized level disagrees with the
  // accepted one, so any bounce back to the accepted level restarts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync  <= '1;
      r_cnt   <= '0;
      r_level <= 1'b1;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], key_n};
      r_pulse <= 1'b0;
      if (w_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= w_sync;
        r_cnt   <= '0;
        r_pulse <= ~w_sync;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  assign pressPulse = r_pulse;
  assign level      = r_level;

endmodule

// File: rtl/operand_sequencer.sv
// Steps the user through op select, operand A, operand B (skipped for NOT),
// one run cycle and result display, driving the logical unit and latching its result.
module operand_sequencer
  import operand_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] switches,
  input  logic       enterKey_n,
  input  logic       clearKey_n,
  input  logic [7:0] resultIn,
  output logic [3:0] x,
  output logic [3:0] y,
  output logic [7:0] z,
  output logic [1:0] operation,
  output logic       operandValid,
  output logic [7:0] resultLatched,
  output logic [2:0] stepState
);

  logic w_enter_pulse;
  logic w_clear_pulse;
  // Debounced levels are available for status use but not needed here.
  logic w_enter_level_unused;
  logic w_clear_level_unused;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_enter_key (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_n      (enterKey_n),
    .pressPulse (w_enter_pulse),
    .level      (w_enter_level_unused)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_clear_key (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_n      (clearKey_n),
    .pressPulse (w_clear_pulse),
    .level      (w_clear_level_unused)
  );

  step_t      r_state, w_state_nxt;
  op_t        r_op, w_op_nxt;
  logic [3:0] r_x, w_x_nxt;
  logic [3:0] r_y, w_y_nxt;
  logic [7:0] r_z, w_z_nxt;
  logic [7:0] r_result, w_result_nxt;
  logic       r_valid, w_valid_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= SEL_OP;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op     <= OP_AND;
      r_x      <= '0;
      r_y      <= '0;
      r_z      <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_op     <= w_op_nxt;
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_z      <= w_z_nxt;
      r_result <= w_result_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_op_nxt     = r_op;
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_z_nxt      = r_z;
    w_result_nxt = r_result;

    // Clear takes priority over everything, including a coincident enter.
    if (w_clear_pulse) begin
      w_state_nxt  = SEL_OP;
      w_op_nxt     = OP_AND;
      w_x_nxt      = '0;
      w_y_nxt      = '0;
      w_z_nxt      = '0;
      w_result_nxt = '0;
    end else begin
      case (r_state)
        SEL_OP: begin
          if (w_enter_pulse) begin
            w_op_nxt    = op_t'(switches[1:0]);
            w_state_nxt = LOAD_A;
          end
        end
        LOAD_A: begin
          if (w_enter_pulse) begin
            if (is_unary(r_op)) begin
              w_z_nxt     = switches;
              w_x_nxt     = '0;
              w_y_nxt     = '0;
              w_state_nxt = RUN;
            end else begin
              w_x_nxt     = switches[3:0];
              w_z_nxt     = '0;
              w_state_nxt = LOAD_B;
            end
          end
        end
        LOAD_B: begin
          if (w_enter_pulse) begin
            w_y_nxt     = switches[3:0];
            w_state_nxt = RUN;
          end
        end
        RUN: begin
          w_result_nxt = resultIn;
          w_state_nxt  = SHOW;
        end
        SHOW: begin
          if (w_enter_pulse) begin
            w_state_nxt = SEL_OP;
          end
        end
        default: begin
          w_state_nxt = SEL_OP;
        end
      endcase
    end

    w_valid_nxt = (w_state_nxt == RUN) || (w_state_nxt == SHOW);
  end

  assign x             = r_x;
  assign y             = r_y;
  assign z             = r_z;
  assign operation     = r_op;
  assign operandValid  = r_valid;
  assign resultLatched = r_result;
  assign stepState     = r_state;

endmodule

// File: tb/tb_operand_sequencer.sv
// Self-checking bench for operand_sequencer: directed scenarios plus random
// operation sequences, checked against a step-level behavioural model.
module tb_operand_sequencer;

  localparam int unsigned D = 4;
  localparam int unsigned S = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] switches;
  logic       enterKey_n;
  logic       clearKey_n;
  logic [7:0] resultIn;
  logic [3:0] x;
  logic [3:0] y;
  logic [7:0] z;
  logic [1:0] operation;
  logic       operandValid;
  logic [7:0] resultLatched;
  logic [2:0] stepState;

  bit and_only = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  int run_cycles  = 0;
  int run_valid   = 0;
  int loadb_cycles = 0;
  int advances    = 0;
  int stable_viol = 0;
  logic [2:0]  prev_state = 3'd0;
  logic        prev_valid = 1'b0;
  logic [17:0] prev_ops   = '0;

  // model state
  int         m_state;
  logic [1:0] m_op;
  logic [3:0] m_x, m_y;
  logic [7:0] m_z, m_res;
  logic       m_valid;

  always #5 clk = ~clk;

  function automatic logic [7:0] lu(input logic [1:0] op, input logic [3:0] a,
                                    input logic [3:0] b, input logic [7:0] c,
                                    input bit andonly);
    logic [7:0] r;
    if (andonly) r = {4'h0, a & b};
    else begin
      case (op)
        2'b00:   r = {4'h0, a & b};
        2'b01:   r = {4'h0, a | b};
        2'b10:   r = {4'h0, a ^ b};
        default: r = ~c;
      endcase
    end
    return r;
  endfunction

  assign resultIn = lu(operation, x, y, z, and_only);

  operand_sequencer #(
    .DEBOUNCE_CYCLES (D),
    .SYNC_STAGES     (S)
  ) u_dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .switches      (switches),
    .enterKey_n    (enterKey_n),
    .clearKey_n    (clearKey_n),
    .resultIn      (resultIn),
    .x             (x),
    .y             (y),
    .z             (z),
    .operation     (operation),
    .operandValid  (operandValid),
    .resultLatched (resultLatched),
    .stepState     (stepState)
  );

  always @(negedge clk) begin
    if (stepState == 3'd3) run_cycles <= run_cycles + 1;
    if (stepState == 3'd3 && operandValid) run_valid <= run_valid + 1;
    if (stepState == 3'd2) loadb_cycles <= loadb_cycles + 1;
    if (stepState != prev_state) advances <= advances + 1;
    if (operandValid && prev_valid && ({x, y, z, operation} != prev_ops))
      stable_viol <= stable_viol + 1;
    prev_state <= stepState;
    prev_valid <= operandValid;
    prev_ops   <= {x, y, z, operation};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"},  32'(stepState),     32'(m_state));
    check({tag, ".op"},     32'(operation),     32'(m_op));
    check({tag, ".x"},      32'(x),             32'(m_x));
    check({tag, ".y"},      32'(y),             32'(m_y));
    check({tag, ".z"},      32'(z),             32'(m_z));
    check({tag, ".valid"},  32'(operandValid),  32'(m_valid));
    check({tag, ".result"}, 32'(resultLatched), 32'(m_res));
  endtask

  task automatic m_reset();
    m_state = 0; m_op = 2'b00; m_x = '0; m_y = '0; m_z = '0; m_res = '0; m_valid = 1'b0;
  endtask

  task automatic m_run();
    m_res   = lu(m_op, m_x, m_y, m_z, and_only);
    m_valid = 1'b1;
    m_state = 4;
  endtask

  task automatic m_enter(input logic [7:0] sw);
    case (m_state)
      0: begin m_op = sw[1:0]; m_state = 1; end
      1: begin
        if (m_op == 2'b11) begin m_z = sw; m_x = '0; m_y = '0; m_run(); end
        else begin m_x = sw[3:0]; m_z = '0; m_state = 2; end
      end
      2: begin m_y = sw[3:0]; m_run(); end
      4: begin m_state = 0; m_valid = 1'b0; end
      default: ;
    endcase
  endtask

  task automatic press(input logic [7:0] sw, input bit use_enter, input bit use_clear);
    @(negedge clk);
    switches = sw;
    if (use_enter) enterKey_n = 1'b0;
    if (use_clear) clearKey_n = 1'b0;
    repeat (D + S + 6) @(negedge clk);
    enterKey_n = 1'b1;
    clearKey_n = 1'b1;
    repeat (D + S + 6) @(negedge clk);
    #1;
  endtask

  task automatic enter(input logic [7:0] sw, input string tag);
    press(sw, 1'b1, 1'b0);
    m_enter(sw);
    check_all(tag);
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int r0, v0, b0, a0, k;
    bit found;
    logic [7:0] rs;

    reset_n = 1'b0; enterKey_n = 1'b1; clearKey_n = 1'b1; switches = '0;
    m_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk); #1;
    check_all("reset");

    // binary op, environment returns x&y
    and_only = 1'b1;
    enter(8'h01, "bin_op");
    check("bin_op_is_or", 32'(operation), 32'h1);
    enter(8'h0C, "bin_a");
    r0 = run_cycles; v0 = run_valid;
    enter(8'h0A, "bin_b");
    check("bin_run_cycles", 32'(run_cycles - r0), 32'd1);
    check("bin_run_valid",  32'(run_valid - v0),  32'd1);
    check("bin_result_08",  32'(resultLatched),   32'h08);
    and_only = 1'b0;

    // NOT skips LOAD_B
    enter(8'h00, "not_leave_show");
    enter(8'h03, "not_op");
    b0 = loadb_cycles;
    enter(8'hA5, "not_z");
    check("not_no_loadb",  32'(loadb_cycles - b0), 32'd0);
    check("not_result_5a", 32'(resultLatched),     32'h5A);

    // bouncing enter: one advance, timed from the last raw edge
    a0 = advances;
    @(negedge clk); switches = 8'h00;
    enterKey_n = 1'b0; repeat (2) @(negedge clk);
    enterKey_n = 1'b1; repeat (2) @(negedge clk);
    enterKey_n = 1'b0; repeat (2) @(negedge clk);
    enterKey_n = 1'b1; repeat (2) @(negedge clk);
    enterKey_n = 1'b0;
    k = 0; found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); k++;
      if (!found && stepState != 3'd4) begin
        found = 1'b1;
        check("bounce_latency", 32'(k), 32'(D + S + 1));
      end
    end
    check("bounce_found", 32'(found), 32'd1);
    enterKey_n = 1'b1;
    repeat (20) @(negedge clk); #1;
    m_enter(8'h00);
    check("bounce_one_advance", 32'(advances - a0), 32'd1);
    check_all("bounce");

    // clear and enter coincident in LOAD_B
    enter(8'h02, "clr_op");
    enter(8'h07, "clr_a");
    press(8'h0B, 1'b1, 1'b1);
    m_reset();
    check_all("clr_enter");

    // async reset while showing 0F
    enter(8'h00, "rst_op");
    enter(8'h0F, "rst_a");
    enter(8'h0F, "rst_b");
    check("rst_result_0f", 32'(resultLatched), 32'h0F);
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    m_reset();
    check_all("async_reset");
    #1 reset_n = 1'b1;
    enter(8'h02, "post_reset_op");

    // enter pulse forced during RUN is ignored
    enter(8'h01, "run_a");
    @(negedge clk);
    switches = 8'h06;
    enterKey_n = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (stepState == 3'd3) begin found = 1'b1; break; end
    end
    check("run_reached", 32'(found), 32'd1);
    force u_dut.w_enter_pulse = 1'b1;
    @(negedge clk);
    release u_dut.w_enter_pulse;
    #1;
    check("run_enter_ignored", 32'(stepState), 32'd4);
    repeat (D + S + 4) @(negedge clk);
    enterKey_n = 1'b1;
    repeat (D + S + 6) @(negedge clk); #1;
    m_enter(8'h06);
    check_all("run_show");

    // random sequences
    enter(8'h00, "rnd_start");
    for (int t = 0; t < 8; t++) begin
      rs = 8'($urandom);
      enter(rs, "rnd_op");
      if (t % 4 == 3) begin
        press(8'($urandom), 1'b0, 1'b1);
        m_reset();
        check_all("rnd_clear");
        continue;
      end
      rs = 8'($urandom);
      enter(rs, "rnd_a");
      if (m_state == 2) begin
        rs = 8'($urandom);
        enter(rs, "rnd_b");
      end
      enter(8'($urandom), "rnd_back");
    end

    check("operands_stable_while_valid", 32'(stable_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
